// File: rtl/fifo_drain_arbiter_pkg.sv
// rtl/fifo_drain_arbiter_pkg.sv - shared state encoding, width helper and channel-id type
package fifo_drain_arbiter_pkg;

    // Scheduler states: arbitrate, drain one channel, pulse the FIFO clear.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    localparam int MAX_CH = 16;

    // Number of bits needed to encode 'value' distinct codes (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    localparam int CH_ID_W = clog2(MAX_CH);

    // Wide enough for any channel index the block supports.
    typedef logic [CH_ID_W-1:0] ch_id_t;

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// rtl/fifo_drain_arbiter_rr_pick.sv - combinational round-robin channel selector
module fifo_drain_arbiter_rr_pick
    import fifo_drain_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic              valid_o,
    output logic [CH_W-1:0]   idx_o
);

    ch_id_t cand;

    // Scan from furthest to nearest offset after 'last' so the nearest requester wins;
    // the modulo keeps the wrap correct for non-power-of-two channel counts.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = ch_id_t'((int'(last_i) + k) % NUM_CH);
            if (req_i[cand[CH_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - round-robin burst drain of show-ahead FIFOs into one tagged stream
module fifo_drain_arbiter
    import fifo_drain_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CH       = 4,
    parameter int BURST_LEN    = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                         rdclk,
    input  logic                         clear_n,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         flush,
    input  logic [NUM_CH-1:0]            rdempty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] q,
    output logic [NUM_CH-1:0]            rdreq,
    output logic                         fifo_clear,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [clog2(NUM_CH)-1:0]     out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int CH_W  = clog2(NUM_CH);
    localparam int CNT_W = clog2(BURST_LEN + 1);
    localparam int CLR_W = clog2(CLEAR_CYCLES + 1);

    state_e                state_q;
    logic [CH_W-1:0]       sel_q;
    logic [CH_W-1:0]       last_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CLR_W-1:0]      clr_cnt_q;
    logic                  flush_pend_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_ch_q;
    logic                  out_valid_q;
    logic                  fifo_clear_q;

    logic                  load;
    logic                  pop;
    logic                  flush_req;
    logic                  sel_avail;
    logic                  pick_valid;
    logic [CH_W-1:0]       pick_idx;
    logic [NUM_CH-1:0]     req_vec;
    logic [DATA_WIDTH-1:0] sel_word;

    assign req_vec   = ch_en & ~rdempty;
    assign load      = !out_valid_q || out_ready;
    // A flush seen while the output was stalled is remembered until the clear starts.
    assign flush_req = flush || flush_pend_q;
    assign sel_avail = ch_en[sel_q] && !rdempty[sel_q];
    assign pop       = clear_n && (state_q == ST_BURST) && sel_avail && load && !flush_req;
    assign sel_word  = q[int'(sel_q) * DATA_WIDTH +: DATA_WIDTH];

    fifo_drain_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req_i   (req_vec),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Pop strobe goes only to the selected channel, and only in a cycle that loads a word.
    always_comb begin
        rdreq = '0;
        if (pop) begin
            rdreq[sel_q] = 1'b1;
        end
    end

    // Scheduler FSM with the output register, burst counter and clear timer.
    always_ff @(posedge rdclk) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            last_q       <= CH_W'(NUM_CH - 1);
            cnt_q        <= '0;
            clr_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            fifo_clear_q <= 1'b0;
        end else begin
            if (pop) begin
                out_data_q  <= sel_word;
                out_ch_q    <= sel_q;
                out_valid_q <= 1'b1;
            end else if (load) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_BURST: begin
                    if (flush_req) begin
                        if (load) begin
                            state_q      <= ST_CLEAR;
                            clr_cnt_q    <= CLR_W'(CLEAR_CYCLES);
                            fifo_clear_q <= 1'b1;
                            flush_pend_q <= 1'b0;
                        end else begin
                            flush_pend_q <= 1'b1;
                        end
                    end else if (state_q == ST_IDLE) begin
                        if (pick_valid) begin
                            sel_q   <= pick_idx;
                            cnt_q   <= '0;
                            state_q <= ST_BURST;
                        end
                    end else if (pop) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                            state_q <= ST_IDLE;
                            last_q  <= sel_q;
                        end
                    end else if (!sel_avail) begin
                        state_q <= ST_IDLE;
                        last_q  <= sel_q;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q <= CLR_W'(1)) begin
                        state_q      <= ST_IDLE;
                        fifo_clear_q <= 1'b0;
                        last_q       <= CH_W'(NUM_CH - 1);
                    end else begin
                        clr_cnt_q <= clr_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign fifo_clear = fifo_clear_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - randomized self-checking bench with FIFO and scheduling model
module tb_fifo_drain_arbiter;

    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int BL  = 8;
    localparam int CC  = 4;

    logic             rdclk = 1'b0;
    logic             clear_n;
    logic [NCH-1:0]   ch_en;
    logic             flush;
    logic [NCH-1:0]   rdempty;
    logic [NCH*DW-1:0] q;
    logic [NCH-1:0]   rdreq;
    logic             fifo_clear;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    fifo_drain_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_CH       (NCH),
        .BURST_LEN    (BL),
        .CLEAR_CYCLES (CC)
    ) dut (
        .rdclk      (rdclk),
        .clear_n    (clear_n),
        .ch_en      (ch_en),
        .flush      (flush),
        .rdempty    (rdempty),
        .q          (q),
        .rdreq      (rdreq),
        .fifo_clear (fifo_clear),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 rdclk = ~rdclk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [DW-1:0] mem [NCH][256];
    int head [NCH];
    int tail [NCH];

    int ready_mode;
    logic [NCH-1:0] rdreq_seen;
    int rdreq_cnt, clear_hi, clear_first, clear_last;

    int rx_ch[$], rx_data[$], rx_cyc[$];
    int ex_ch[$], ex_data[$];
    bit ex_first[$];

    bit hold_pending;
    logic [DW-1:0] held_d;
    logic [1:0]    held_c;

    task automatic push_word(input int ch, input logic [DW-1:0] d);
        mem[ch][tail[ch][7:0]] = d;
        tail[ch]++;
    endtask

    task automatic fifo_reset();
        for (int i = 0; i < NCH; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic step();
        for (int i = 0; i < NCH; i++) begin
            rdempty[i]      = (head[i] == tail[i]);
            q[i*DW +: DW]   = mem[i][head[i][7:0]];
        end
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = cyc[0];
            2: out_ready = (($urandom % 4) != 0);
            default: ;
        endcase
        #1;
        tests_run++;
        if (($countones(rdreq) > 1) || ((rdreq & rdempty) != 0) ||
            ((rdreq & ~ch_en) != 0) || (!clear_n && rdreq != 0)) begin
            tests_failed++;
            $display("FAIL rdreq_rules: rdreq=%b rdempty=%b ch_en=%b clear_n=%b", rdreq, rdempty, ch_en, clear_n);
        end
        if (hold_pending) begin
            tests_run++;
            if (!out_valid || out_data !== held_d || out_ch !== held_c) begin
                tests_failed++;
                $display("FAIL stall_hold: got valid=%b data=%h ch=%0d expected valid=1 data=%h ch=%0d",
                         out_valid, out_data, out_ch, held_d, held_c);
            end
        end
        hold_pending = out_valid && !out_ready && clear_n;
        held_d = out_data;
        held_c = out_ch;
        if (out_valid && out_ready && clear_n) begin
            rx_ch.push_back(int'(out_ch));
            rx_data.push_back(int'(out_data));
            rx_cyc.push_back(cyc);
        end
        for (int i = 0; i < NCH; i++) begin
            if (rdreq[i]) head[i]++;
        end
        rdreq_seen |= rdreq;
        rdreq_cnt  += $countones(rdreq);
        if (fifo_clear) begin
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy_in_clear: got %b expected 1", busy);
            end
            if (clear_hi == 0) clear_first = cyc;
            clear_last = cyc;
            clear_hi++;
            for (int i = 0; i < NCH; i++) head[i] = tail[i];
        end
        @(posedge rdclk);
        @(negedge rdclk);
        cyc++;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        fifo_reset();
        step();
        clear_n = 1'b1;
    endtask

    // Reference: drain static FIFO contents by round-robin bursts of at most BL words.
    task automatic build_expected();
        int cnt [NCH];
        int hd [NCH];
        int last, c, n;
        bit found, done;
        ex_ch.delete(); ex_data.delete(); ex_first.delete();
        for (int i = 0; i < NCH; i++) begin
            cnt[i] = tail[i] - head[i];
            hd[i]  = head[i];
        end
        last = NCH - 1;
        done = 0;
        c = 0;
        while (!done) begin
            found = 0;
            for (int k = 1; k <= NCH && !found; k++) begin
                c = (last + k) % NCH;
                if (ch_en[c] && cnt[c] > 0) found = 1;
            end
            if (!found) begin
                done = 1;
            end else begin
                n = (cnt[c] < BL) ? cnt[c] : BL;
                for (int j = 0; j < n; j++) begin
                    ex_ch.push_back(c);
                    ex_data.push_back(int'(mem[c][hd[c][7:0]]));
                    ex_first.push_back(j == 0);
                    hd[c]++;
                end
                cnt[c] -= n;
                last = c;
            end
        end
    endtask

    task automatic run_and_compare(input string name, input int budget);
        int n;
        n = 0;
        build_expected();
        rx_ch.delete(); rx_data.delete(); rx_cyc.delete();
        while (rx_ch.size() < ex_ch.size() && n < budget) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, rx_ch.size(), ex_ch.size());
        end
        repeat (6) step();
        tests_run++;
        if (rx_ch.size() != ex_ch.size()) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d expected %0d", name, rx_ch.size(), ex_ch.size());
        end else begin
            for (int i = 0; i < ex_ch.size(); i++) begin
                tests_run++;
                if (rx_ch[i] !== ex_ch[i] || rx_data[i] !== ex_data[i]) begin
                    tests_failed++;
                    $display("FAIL %s_word%0d: got ch%0d/%h expected ch%0d/%h",
                             name, i, rx_ch[i], rx_data[i], ex_ch[i], ex_data[i]);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 ||
            fifo_clear !== 1'b0 || busy !== 1'b0 || rdreq !== '0) begin
            tests_failed++;
            $display("FAIL %s: got valid=%b data=%h ch=%0d clr=%b busy=%b rdreq=%b expected all 0",
                     name, out_valid, out_data, out_ch, fifo_clear, busy, rdreq);
        end
    endtask

    task automatic test_reset();
        do_reset();
        clear_n = 1'b0;
        step();
        check_idle_outputs("reset_state");
        clear_n = 1'b1;
    endtask

    task automatic test_single_channel();
        int base;
        do_reset();
        for (int j = 0; j < 20; j++) push_word(0, DW'($urandom));
        base = cyc;
        run_and_compare("single", 200);
        if (rx_cyc.size() == 20) begin
            tests_run++;
            if (rx_cyc[0] - base != 2) begin
                tests_failed++;
                $display("FAIL first_latency: got %0d expected 2", rx_cyc[0] - base);
            end
            for (int i = 1; i < 20; i++) begin
                tests_run++;
                if (rx_cyc[i] - rx_cyc[i-1] != (ex_first[i] ? 2 : 1)) begin
                    tests_failed++;
                    $display("FAIL burst_gap%0d: got %0d expected %0d", i,
                             rx_cyc[i] - rx_cyc[i-1], ex_first[i] ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_all_channels();
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < 3; j++) push_word(c, DW'($urandom));
        run_and_compare("all_ch", 200);
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int j = 0; j < 10; j++) push_word(1, DW'($urandom));
        ready_mode = 1;
        run_and_compare("toggle_ready", 200);
        ready_mode = 0;
    endtask

    task automatic test_ch_mask();
        do_reset();
        ch_en = 4'b1011;
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < 5; j++) push_word(c, DW'($urandom));
        rdreq_seen = '0;
        run_and_compare("ch_mask", 300);
        tests_run++;
        if (rdreq_seen[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_rdreq2: got %b expected 0", rdreq_seen[2]);
        end
        ch_en = '1;
    endtask

    task automatic test_flush();
        int n, rx_before;
        logic [DW-1:0] held_word;
        do_reset();
        for (int j = 0; j < 20; j++) push_word(0, DW'($urandom));
        ready_mode = 3;
        out_ready  = 1'b1;
        rx_ch.delete(); rx_data.delete(); rx_cyc.delete();
        n = 0;
        while (rx_ch.size() < 3 && n < 50) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        step();
        step();
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_stalled_word: got valid=%b expected 1", out_valid);
        end
        held_word = out_data;
        rx_before = rx_ch.size();
        rdreq_cnt = 0;
        clear_hi  = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        repeat (12) step();
        tests_run++;
        if (rdreq_cnt != 0) begin
            tests_failed++;
            $display("FAIL flush_no_pop: got %0d pops expected 0", rdreq_cnt);
        end
        tests_run++;
        if (rx_ch.size() != rx_before + 1 || rx_data[rx_ch.size()-1] !== int'(held_word)) begin
            tests_failed++;
            $display("FAIL flush_held_word: got %0d new words expected 1 of %h", rx_ch.size() - rx_before, held_word);
        end
        tests_run++;
        if (clear_hi != CC || clear_last - clear_first + 1 != CC) begin
            tests_failed++;
            $display("FAIL clear_len: got %0d cycles span %0d expected %0d", clear_hi, clear_last - clear_first + 1, CC);
        end
        ready_mode = 0;
        for (int c = NCH - 1; c >= 0; c--)
            for (int j = 0; j < 2; j++) push_word(c, DW'($urandom));
        run_and_compare("after_flush", 200);
        tests_run++;
        if (rx_ch.size() == 0 || rx_ch[0] !== 0) begin
            tests_failed++;
            $display("FAIL flush_next_grant: got ch%0d expected ch0", rx_ch.size() ? rx_ch[0] : -1);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int j = 0; j < 20; j++) push_word(2, DW'($urandom));
        repeat (5) step();
        clear_n = 1'b0;
        step();
        check_idle_outputs("mid_reset_state");
        clear_n = 1'b1;
        for (int j = 0; j < 3; j++) push_word(0, DW'($urandom));
        run_and_compare("after_reset", 300);
        tests_run++;
        if (rx_ch.size() == 0 || rx_ch[0] !== 0) begin
            tests_failed++;
            $display("FAIL reset_next_grant: got ch%0d expected ch0", rx_ch.size() ? rx_ch[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            ch_en = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                int len;
                len = $urandom % 13;
                for (int j = 0; j < len; j++) push_word(c, DW'($urandom));
            end
            ready_mode = 2;
            run_and_compare("random", 800);
        end
        ready_mode = 0;
        ch_en = '1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_n    = 1'b0;
        ch_en      = '1;
        flush      = 1'b0;
        out_ready  = 1'b1;
        ready_mode = 0;
        rdreq_seen = '0;
        rdreq_cnt  = 0;
        clear_hi   = 0;
        clear_first = 0;
        clear_last = 0;
        hold_pending = 0;
        fifo_reset();
        @(negedge rdclk);
        test_reset();
        test_single_channel();
        test_all_channels();
        test_back_pressure();
        test_ch_mask();
        test_flush();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
